// File: rtl/main_daq.sv
// main_daq: drift-tube DAQ front end.
//   A scintillator coincidence opens an acquisition window of WINDOW_CYCLES clk100 ticks.
//   The first rising edge on each of 32 tube discriminator lines is time-stamped in ticks since
//   the trigger. The bench reads back a header word and per-channel hit words from an internal
//   FIFO.
// Ports:
//   clk100                        sole clock, rising edge
//   RST                           asynchronous active-high reset
//   SCIN_COIN                     asynchronous trigger input
//   TUBE3A/TUBE3B/TUBE4A/TUBE4B   asynchronous hit lines, channels 0-7/8-15/16-23/24-31
//   RD_CLK                        pin-compatibility only, unused
//   RD_EN                         read request, sampled on clk100
//   OTUBE                         read data word
//   RD_EMPTY                      FIFO empty, combinational from the pointers
//   RD_VALID                      OTUBE was loaded by the previous cycle's read
//   overflowLight                 sticky flag, a word was dropped on a full FIFO
// Word formats: header {1'b1, event_count[14:0]}, hit {1'b0, channel[4:0], time[9:0]}.
module main_daq #(
  parameter int unsigned WINDOW_CYCLES = 100,
  parameter int unsigned FIFO_DEPTH    = 512
) (
  input  logic        clk100,
  input  logic        RST,
  input  logic        SCIN_COIN,
  input  logic [7:0]  TUBE3A,
  input  logic [7:0]  TUBE3B,
  input  logic [7:0]  TUBE4A,
  input  logic [7:0]  TUBE4B,
  input  logic        RD_CLK,
  input  logic        RD_EN,
  output logic [15:0] OTUBE,
  output logic        RD_EMPTY,
  output logic        RD_VALID,
  output logic        overflowLight
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  LastCnt = 10'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAcq,
    StDrain
  } state_e;

  logic w_unused_rd_clk;
  assign w_unused_rd_clk = RD_CLK;

  // ---------------------------------------------------------------------------------------------
  // Input synchronizers and rising-edge detection. Bit 32 is the trigger, bits 31:0 the tubes.
  // All 33 lines share the same latency, so hit offsets relative to the trigger are preserved.
  // ---------------------------------------------------------------------------------------------
  logic [32:0] w_raw;
  logic [32:0] r_sync1;
  logic [32:0] r_sync2;
  logic [32:0] r_prev;
  logic [32:0] w_rise;

  assign w_raw = {SCIN_COIN, TUBE4B, TUBE4A, TUBE3B, TUBE3A};

  always_ff @(posedge clk100 or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;

  // ---------------------------------------------------------------------------------------------
  // Acquisition FSM and timebase.
  // The counter reads 0 in the trigger cycle (still StIdle) and k in the k-th cycle after it, so
  // a hit's timestamp equals its distance from the trigger edge.
  // ---------------------------------------------------------------------------------------------
  state_e     r_state;
  state_e     w_state_d;
  logic [9:0] r_cnt;
  logic [9:0] w_cnt_d;
  logic       w_trig;
  logic       w_acq_open;

  logic [31:0] r_armed;
  logic [31:0] r_pend;
  logic        r_hdr_pend;
  logic [14:0] r_evt_cnt;
  logic [9:0]  r_time [32];
  logic [31:0] w_accept;
  logic [31:0] w_pend_clr;

  // Triggers outside StIdle are ignored entirely.
  assign w_trig = w_rise[32] && (r_state == StIdle);

  // The range check keeps a one-cycle window from accepting a timestamp of 1.
  assign w_acq_open = (r_state == StAcq) && (r_cnt <= LastCnt);

  assign w_accept = w_rise[31:0] & r_armed & {32{w_acq_open}};

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_trig) begin
          w_state_d = StAcq;
          w_cnt_d   = 10'd1;
        end
      end
      StAcq: begin
        if (r_cnt >= LastCnt) begin
          w_state_d = StDrain;
        end else begin
          w_cnt_d = r_cnt + 10'd1;
        end
      end
      StDrain: begin
        if (!r_hdr_pend && (r_pend == '0)) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk100 or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Per-channel armed/pending flags and time registers.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk100 or posedge RST) begin
    if (RST) begin
      r_armed    <= '0;
      r_pend     <= '0;
      r_hdr_pend <= 1'b0;
      r_evt_cnt  <= '0;
      for (int i = 0; i < 32; i++) begin
        r_time[i] <= '0;
      end
    end else begin
      if (w_trig) begin
        r_armed    <= '1;
        r_pend     <= '0;
        r_hdr_pend <= 1'b1;
      end else begin
        r_armed <= r_armed & ~w_accept;
        r_pend  <= (r_pend & ~w_pend_clr) | w_accept;
        // The event is counted even when its header is dropped on a full FIFO.
        if (r_hdr_pend) begin
          r_hdr_pend <= 1'b0;
          r_evt_cnt  <= r_evt_cnt + 15'd1;
        end
      end
      for (int i = 0; i < 32; i++) begin
        if (w_accept[i]) begin
          r_time[i] <= r_cnt;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Serializer: at most one FIFO write per cycle, header first, then the lowest pending channel.
  // ---------------------------------------------------------------------------------------------
  logic [4:0]  w_sel;
  logic        w_wr_req;
  logic [15:0] w_wr_data;

  always_comb begin
    w_sel = '0;
    for (int i = 31; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel = 5'(i);
      end
    end
    w_wr_req   = 1'b0;
    w_wr_data  = '0;
    w_pend_clr = '0;
    if (r_hdr_pend) begin
      w_wr_req  = 1'b1;
      w_wr_data = {1'b1, r_evt_cnt};
    end else if (|r_pend) begin
      w_wr_req          = 1'b1;
      w_wr_data         = {1'b0, w_sel, r_time[w_sel]};
      w_pend_clr[w_sel] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FIFO with an extra pointer bit to tell full from empty.
  // ---------------------------------------------------------------------------------------------
  logic [15:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;
  logic        w_do_wr;
  logic        w_do_rd;
  logic [15:0] r_otube;
  logic        r_valid;
  logic        r_ovf;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_wr = w_wr_req && !w_full;
  assign w_do_rd = RD_EN && !w_empty;

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk100) begin
    if (w_do_wr) begin
      r_mem[r_wptr[AW-1:0]] <= w_wr_data;
    end
  end

  always_ff @(posedge clk100 or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_otube <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_wr_req && w_full) begin
        r_ovf <= 1'b1;
      end
      r_valid <= w_do_rd;
      if (w_do_rd) begin
        r_otube <= r_mem[r_rptr[AW-1:0]];
        r_rptr  <= r_rptr + 1'b1;
      end
    end
  end

  assign OTUBE         = r_otube;
  assign RD_VALID      = r_valid;
  assign RD_EMPTY      = w_empty;
  assign overflowLight = r_ovf;

endmodule

// File: tb/tb_main_daq.sv
// Testbench for main_daq: directed scenarios plus randomized events checked against an
// event-level reference model (first edge per channel inside the window, header first, then
// lowest eligible channel per write slot, FIFO capacity with drop-on-full).
module tb_main_daq;

  localparam int W     = 100;
  localparam int DEPTH = 512;

  logic        clk100 = 1'b0;
  logic        RST;
  logic        SCIN_COIN;
  logic [7:0]  TUBE3A;
  logic [7:0]  TUBE3B;
  logic [7:0]  TUBE4A;
  logic [7:0]  TUBE4B;
  logic        RD_CLK;
  logic        RD_EN;
  logic [15:0] OTUBE;
  logic        RD_EMPTY;
  logic        RD_VALID;
  logic        overflowLight;

  int n_tests = 0;
  int n_fail  = 0;

  // Event description: rise offset per channel in cycles from the trigger (-1 = never),
  // lines held high before the trigger, lines that toggle after their first rise, retrigger.
  int        ev_rise [32];
  bit [31:0] ev_pre;
  bit [31:0] ev_tog;
  bit        ev_retrig;

  // Reference model state.
  logic [14:0] m_evt;
  logic [15:0] m_q [$];
  bit          m_ovf;
  logic [15:0] m_last;

  logic [15:0] rd_q [$];
  bit          rd_to;

  main_daq #(
    .WINDOW_CYCLES(W),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk100       (clk100),
    .RST          (RST),
    .SCIN_COIN    (SCIN_COIN),
    .TUBE3A       (TUBE3A),
    .TUBE3B       (TUBE3B),
    .TUBE4A       (TUBE4A),
    .TUBE4B       (TUBE4B),
    .RD_CLK       (RD_CLK),
    .RD_EN        (RD_EN),
    .OTUBE        (OTUBE),
    .RD_EMPTY     (RD_EMPTY),
    .RD_VALID     (RD_VALID),
    .overflowLight(overflowLight)
  );

  always #5 clk100 = ~clk100;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_tubes(input logic [31:0] v);
    {TUBE4B, TUBE4A, TUBE3B, TUBE3A} = v;
  endtask

  task automatic apply_reset();
    @(negedge clk100);
    RST       = 1'b1;
    SCIN_COIN = 1'b0;
    RD_EN     = 1'b0;
    set_tubes('0);
    repeat (3) @(negedge clk100);
    RST   = 1'b0;
    m_evt = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic clear_event();
    for (int i = 0; i < 32; i++) ev_rise[i] = -1;
    ev_pre    = '0;
    ev_tog    = '0;
    ev_retrig = 1'b0;
  endtask

  // Tube line levels at cycle c relative to the trigger rise. Toggling lines rise at r, r+4, r+8.
  function automatic logic [31:0] line_levels(input int c);
    logic [31:0] v;
    v = '0;
    for (int ch = 0; ch < 32; ch++) begin
      int r;
      r = ev_rise[ch];
      if (ev_pre[ch]) begin
        v[ch] = 1'b1;
      end else if (r >= 0 && c >= r) begin
        v[ch] = 1'b1;
        if (ev_tog[ch] && ((c - r) % 4 >= 2) && (c - r) < 8) v[ch] = 1'b0;
      end
    end
    return v;
  endfunction

  function automatic void model_push(input logic [15:0] w);
    if (m_q.size() < DEPTH) m_q.push_back(w);
    else m_ovf = 1'b1;
  endfunction

  // Header goes out in slot 1; a hit first seen at offset d may go out from slot d+1 on, and in
  // every slot the lowest channel still waiting is emitted.
  function automatic void model_event();
    bit hit  [32];
    bit done [32];
    model_push({1'b1, m_evt});
    m_evt = m_evt + 15'd1;
    for (int ch = 0; ch < 32; ch++) begin
      hit[ch]  = !ev_pre[ch] && ev_rise[ch] >= 1 && ev_rise[ch] <= W - 1;
      done[ch] = 1'b0;
    end
    for (int s = 2; s <= W + 40; s++) begin
      for (int ch = 0; ch < 32; ch++) begin
        if (hit[ch] && !done[ch] && ev_rise[ch] + 1 <= s) begin
          model_push({1'b0, 5'(ch), 10'(ev_rise[ch])});
          done[ch] = 1'b1;
          break;
        end
      end
    end
  endfunction

  task automatic run_event();
    model_event();
    for (int c = -5; c <= W + 45; c++) begin
      @(negedge clk100);
      SCIN_COIN = (c >= 0 && c <= 2) || (ev_retrig && c >= 40 && c <= 42);
      set_tubes((c < W + 10) ? line_levels(c) : 32'h0);
    end
  endtask

  task automatic read_all();
    rd_q.delete();
    rd_to = 1'b1;
    @(negedge clk100);
    RD_EN = 1'b1;
    for (int k = 0; k < DEPTH + 20; k++) begin
      @(posedge clk100);
      #1;
      if (RD_VALID) rd_q.push_back(OTUBE);
      if (!RD_VALID && RD_EMPTY) begin
        rd_to = 1'b0;
        break;
      end
    end
    @(negedge clk100);
    RD_EN = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (OTUBE !== 16'h0) begin
      n_fail++; $display("FAIL reset_otube: got %h required 0000", OTUBE);
    end
    n_tests++;
    if (RD_VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b required 0", RD_VALID);
    end
    n_tests++;
    if (RD_EMPTY !== 1'b1) begin
      n_fail++; $display("FAIL reset_empty: got %b required 1", RD_EMPTY);
    end
    n_tests++;
    if (overflowLight !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf: got %b required 0", overflowLight);
    end
  endtask

  task automatic test_hits_basic();
    logic [15:0] exp [5] = '{16'h8000, 16'h100D, 16'h2C10, 16'h4414, 16'h6016};
    clear_event();
    ev_rise[4]  = 13;
    ev_rise[11] = 16;
    ev_rise[17] = 20;
    ev_rise[24] = 22;
    run_event();
    read_all();
    n_tests++;
    if (rd_to) begin
      n_fail++; $display("FAIL basic_timeout: got no empty required empty after drain");
    end
    n_tests++;
    if (rd_q.size() != 5) begin
      n_fail++; $display("FAIL basic_count: got %0d required 5", rd_q.size());
    end
    for (int i = 0; i < 5 && i < rd_q.size(); i++) begin
      n_tests++;
      if (rd_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL basic_word%0d: got %h required %h", i, rd_q[i], exp[i]);
      end
    end
    n_tests++;
    if (RD_EMPTY !== 1'b1) begin
      n_fail++; $display("FAIL basic_empty: got %b required 1", RD_EMPTY);
    end
    m_q.delete();
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp [3] = '{16'h8001, 16'h0807, 16'h1407};
    clear_event();
    ev_rise[5] = 7;
    ev_rise[2] = 7;
    run_event();
    read_all();
    n_tests++;
    if (rd_q.size() != 3) begin
      n_fail++; $display("FAIL simul_count: got %0d required 3", rd_q.size());
    end
    for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
      n_tests++;
      if (rd_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL simul_word%0d: got %h required %h", i, rd_q[i], exp[i]);
      end
    end
    m_q.delete();
  endtask

  task automatic test_toggle_prehigh();
    logic [15:0] exp [2] = '{16'h8002, 16'h241E};
    clear_event();
    ev_rise[9] = 30;
    ev_tog[9]  = 1'b1;
    ev_pre[20] = 1'b1;
    run_event();
    read_all();
    n_tests++;
    if (rd_q.size() != 2) begin
      n_fail++; $display("FAIL toggle_count: got %0d required 2", rd_q.size());
    end
    for (int i = 0; i < 2 && i < rd_q.size(); i++) begin
      n_tests++;
      if (rd_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL toggle_word%0d: got %h required %h", i, rd_q[i], exp[i]);
      end
    end
    m_q.delete();
  endtask

  task automatic test_retrigger();
    logic [15:0] exp [4] = '{16'h8000, 16'h0005, 16'h0C3C, 16'h8001};
    apply_reset();
    clear_event();
    ev_rise[0] = 5;
    ev_rise[3] = 60;
    ev_retrig  = 1'b1;
    run_event();
    clear_event();
    run_event();
    read_all();
    n_tests++;
    if (rd_q.size() != 4) begin
      n_fail++; $display("FAIL retrig_count: got %0d required 4", rd_q.size());
    end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      n_tests++;
      if (rd_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL retrig_word%0d: got %h required %h", i, rd_q[i], exp[i]);
      end
    end
    m_q.delete();
  endtask

  task automatic test_window_edges();
    logic [15:0] exp [3] = '{16'h8000, 16'h1C01, 16'h2063};
    apply_reset();
    clear_event();
    ev_rise[6]  = 0;
    ev_rise[7]  = 1;
    ev_rise[8]  = W - 1;
    ev_rise[9]  = W;
    ev_pre[10]  = 1'b1;
    run_event();
    read_all();
    n_tests++;
    if (rd_q.size() != 3) begin
      n_fail++; $display("FAIL edges_count: got %0d required 3", rd_q.size());
    end
    for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
      n_tests++;
      if (rd_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL edges_word%0d: got %h required %h", i, rd_q[i], exp[i]);
      end
    end
    m_q.delete();
  endtask

  task automatic test_random();
    for (int e = 0; e < 6; e++) begin
      int shared_t;
      shared_t = $urandom_range(W - 1, 1);
      clear_event();
      ev_retrig = ($urandom_range(1, 0) != 0);
      for (int ch = 0; ch < 32; ch++) begin
        int sel;
        sel = $urandom_range(9, 0);
        if (sel >= 4 && sel <= 6) begin
          ev_rise[ch] = $urandom_range(W - 1, 1);
        end else if (sel == 7) begin
          int pick;
          pick = $urandom_range(3, 0);
          ev_rise[ch] = (pick == 0) ? 0 : (pick == 1) ? 1 : (pick == 2) ? W - 1 : W;
        end else if (sel == 8) begin
          ev_rise[ch] = shared_t;
        end else if (sel == 9) begin
          ev_pre[ch] = 1'b1;
        end
        if (ev_rise[ch] >= 1 && $urandom_range(3, 0) == 0) ev_tog[ch] = 1'b1;
      end
      run_event();
      n_tests++;
      if (overflowLight !== m_ovf) begin
        n_fail++; $display("FAIL rand%0d_ovf: got %b required %b", e, overflowLight, m_ovf);
      end
      read_all();
      n_tests++;
      if (rd_q.size() != m_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d required %0d", e, rd_q.size(), m_q.size());
      end
      for (int i = 0; i < m_q.size() && i < rd_q.size(); i++) begin
        n_tests++;
        if (rd_q[i] !== m_q[i]) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %h required %h", e, i, rd_q[i], m_q[i]);
        end
      end
      m_q.delete();
    end
  endtask

  task automatic test_overflow();
    for (int e = 0; e < 16; e++) begin
      clear_event();
      for (int ch = 0; ch < 32; ch++) ev_rise[ch] = $urandom_range(W - 1, 1);
      run_event();
    end
    n_tests++;
    if (overflowLight !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b required 1", overflowLight);
    end
    m_last = m_q[m_q.size() - 1];
    read_all();
    n_tests++;
    if (rd_q.size() != DEPTH) begin
      n_fail++; $display("FAIL ovf_count: got %0d required %0d", rd_q.size(), DEPTH);
    end
    for (int i = 0; i < m_q.size() && i < rd_q.size(); i++) begin
      n_tests++;
      if (rd_q[i] !== m_q[i]) begin
        n_fail++; $display("FAIL ovf_word%0d: got %h required %h", i, rd_q[i], m_q[i]);
      end
    end
    n_tests++;
    if (RD_EMPTY !== 1'b1) begin
      n_fail++; $display("FAIL ovf_empty: got %b required 1", RD_EMPTY);
    end
    n_tests++;
    if (overflowLight !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflowLight);
    end
    m_q.delete();
  endtask

  task automatic test_empty_read_and_reset();
    logic [15:0] exp [2] = '{16'h8000, 16'h040A};
    for (int p = 0; p < 3; p++) begin
      @(negedge clk100);
      RD_EN = 1'b1;
      @(posedge clk100);
      #1;
      n_tests++;
      if (RD_VALID !== 1'b0) begin
        n_fail++; $display("FAIL empty_rd_valid%0d: got %b required 0", p, RD_VALID);
      end
      n_tests++;
      if (OTUBE !== m_last) begin
        n_fail++; $display("FAIL empty_rd_hold%0d: got %h required %h", p, OTUBE, m_last);
      end
      @(negedge clk100);
      RD_EN = 1'b0;
    end
    // Start an event and pull reset in the middle of the window.
    clear_event();
    ev_rise[3] = 5;
    for (int c = -5; c <= 20; c++) begin
      @(negedge clk100);
      SCIN_COIN = (c >= 0 && c <= 2);
      set_tubes(line_levels(c));
    end
    n_tests++;
    if (RD_EMPTY !== 1'b0) begin
      n_fail++; $display("FAIL acq_nonempty: got %b required 0", RD_EMPTY);
    end
    @(negedge clk100);
    RST = 1'b1;
    #1;
    n_tests++;
    if (OTUBE !== 16'h0) begin
      n_fail++; $display("FAIL midrst_otube: got %h required 0000", OTUBE);
    end
    n_tests++;
    if (RD_VALID !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid: got %b required 0", RD_VALID);
    end
    n_tests++;
    if (RD_EMPTY !== 1'b1) begin
      n_fail++; $display("FAIL midrst_empty: got %b required 1", RD_EMPTY);
    end
    n_tests++;
    if (overflowLight !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ovf: got %b required 0", overflowLight);
    end
    set_tubes('0);
    SCIN_COIN = 1'b0;
    repeat (3) @(negedge clk100);
    RST   = 1'b0;
    m_evt = '0;
    m_q.delete();
    m_ovf = 1'b0;
    clear_event();
    ev_rise[1] = 10;
    run_event();
    read_all();
    n_tests++;
    if (rd_q.size() != 2) begin
      n_fail++; $display("FAIL postrst_count: got %0d required 2", rd_q.size());
    end
    for (int i = 0; i < 2 && i < rd_q.size(); i++) begin
      n_tests++;
      if (rd_q[i] !== exp[i]) begin
        n_fail++; $display("FAIL postrst_word%0d: got %h required %h", i, rd_q[i], exp[i]);
      end
    end
    m_q.delete();
  endtask

  initial begin
    RST       = 1'b1;
    RD_CLK    = 1'b0;
    RD_EN     = 1'b0;
    SCIN_COIN = 1'b0;
    set_tubes('0);
    clear_event();
    m_last = '0;
    test_reset();
    test_hits_basic();
    test_simultaneous();
    test_toggle_prehigh();
    test_retrigger();
    test_window_edges();
    test_random();
    test_overflow();
    test_empty_read_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
